// File: rtl/csa_pkg.sv
// Shared widths and word type for the 64-bit carry-select adder tile.
// Pure declarations; no logic, no latency, no flow control.
// Default build leaves CSA64_EQG_INPUT_REG_EN undefined.
package csa_pkg;

    localparam int CSA_WIDTH = 64;
    localparam int CSA_GROUP = 8;
    localparam int CSA_NGRP  = CSA_WIDTH / CSA_GROUP;

    typedef logic [CSA_WIDTH-1:0] csa_word_t;

endpackage

// File: rtl/csa_group.sv
// One carry-select group: ripple sums for carry-in 0 and carry-in 1 side by side.
// Combinational, zero latency; no handshake or backpressure.
module csa_group
    import csa_pkg::*;
#(
    parameter int GROUP = CSA_GROUP
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    output logic [GROUP-1:0] sum0_o,
    output logic             cout0_o,
    output logic [GROUP-1:0] sum1_o,
    output logic             cout1_o
);

    logic [GROUP:0] c0;
    logic [GROUP:0] c1;

    always_comb begin
        c0     = '0;
        c1     = '0;
        c1[0]  = 1'b1;
        sum0_o = '0;
        sum1_o = '0;
        for (int i = 0; i < GROUP; i++) begin
            sum0_o[i] = a_i[i] ^ b_i[i] ^ c0[i];
            c0[i+1]   = (a_i[i] & b_i[i]) | (c0[i] & (a_i[i] ^ b_i[i]));
            sum1_o[i] = a_i[i] ^ b_i[i] ^ c1[i];
            c1[i+1]   = (a_i[i] & b_i[i]) | (c1[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout0_o = c0[GROUP];
    assign cout1_o = c1[GROUP];

endmodule

// File: rtl/csa64_eqg.sv
// 64-bit unsigned carry-select adder, equal groups, registered {crout,sum}.
// Latency 1 clock; 2 clocks with CSA64_EQG_INPUT_REG_EN defined (operand registers).
// No handshake: one addition accepted every clock, never stalls.
module csa64_eqg
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int GROUP = CSA_GROUP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] sum,
    output logic             crout
);

    localparam int NGRP = WIDTH / GROUP;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;

`ifdef CSA64_EQG_INPUT_REG_EN
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op1_q <= '0;
            op2_q <= '0;
        end else begin
            op1_q <= op1;
            op2_q <= op2;
        end
    end

    assign add_a = op1_q;
    assign add_b = op2_q;
`else
    assign add_a = op1;
    assign add_b = op2;
`endif

    logic [NGRP-1:0][GROUP-1:0] gsum0;
    logic [NGRP-1:0][GROUP-1:0] gsum1;
    logic [NGRP-1:0]            gcout0;
    logic [NGRP-1:0]            gcout1;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        csa_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a_i     (add_a[g*GROUP +: GROUP]),
            .b_i     (add_b[g*GROUP +: GROUP]),
            .sum0_o  (gsum0[g]),
            .cout0_o (gcout0[g]),
            .sum1_o  (gsum1[g]),
            .cout1_o (gcout1[g])
        );
    end

    // gc[g] is the true carry into group g; gc[0] is tied low so group 0 is a plain ripple add.
    logic [NGRP:0]    gc;
    logic [WIDTH-1:0] sum_d;
    logic             crout_d;

    always_comb begin
        gc    = '0;
        sum_d = '0;
        for (int g = 0; g < NGRP; g++) begin
            sum_d[g*GROUP +: GROUP] = gc[g] ? gsum1[g]  : gsum0[g];
            gc[g+1]                 = gc[g] ? gcout1[g] : gcout0[g];
        end
        crout_d = gc[NGRP];
    end

    logic [WIDTH-1:0] sum_q;
    logic             crout_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q   <= '0;
            crout_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            crout_q <= crout_d;
        end
    end

    assign sum   = sum_q;
    assign crout = crout_q;

endmodule

// File: tb/tb_csa64_eqg.sv
// Scoreboard bench for csa64_eqg: driver queues expected {crout,sum}, monitor pops after every edge.
// Expected latency follows CSA64_EQG_INPUT_REG_EN.
module tb_csa64_eqg;

`ifdef CSA64_EQG_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock;
    logic        reset;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] sum;
    logic        crout;

    csa64_eqg dut (
        .clock (clock),
        .reset (reset),
        .op1   (op1),
        .op2   (op2),
        .sum   (sum),
        .crout (crout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [64:0] exp_q[$];
    logic [64:0] pipe[$];
    int          mon_idx = 0;

    // Hand-computed directed vectors: op1, op2, {crout,sum}.
    localparam int NDIR = 9;
    logic [63:0] d_a [NDIR] = '{
        64'h1010_1010_1199_ffff, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff,
        64'h0000_0000_0000_00ff, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000,
        64'h00ff_00ff_00ff_00ff, 64'h0123_4567_89ab_cdef, 64'h7fff_ffff_ffff_ffff};
    logic [63:0] d_b [NDIR] = '{
        64'habcd_1100_1100_dddd, 64'h0000_0000_0000_0001, 64'hffff_ffff_ffff_ffff,
        64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000,
        64'h0001_0001_0001_0001, 64'hfedc_ba98_7654_3210, 64'h0000_0000_0000_0001};
    logic [64:0] d_e [NDIR] = '{
        {1'b0, 64'hbbdd_2110_229a_dddc}, {1'b1, 64'h0000_0000_0000_0000},
        {1'b1, 64'hffff_ffff_ffff_fffe}, {1'b0, 64'h0000_0000_0000_0100},
        {1'b0, 64'h0000_0000_0000_0000}, {1'b1, 64'h0000_0000_0000_0000},
        {1'b0, 64'h0100_0100_0100_0100}, {1'b0, 64'hffff_ffff_ffff_ffff},
        {1'b0, 64'h8000_0000_0000_0000}};

    task automatic drive(input logic rst, input logic [63:0] a, input logic [63:0] b,
                         input logic [64:0] res);
        @(negedge clock);
        if (!rst && reset) begin
            reset = 1'b0;
            op1   = a;
            op2   = b;
            #1;
            n_cmp++;
            if ({crout, sum} !== 65'd0) begin
                n_bad++;
                $display("FAIL async_clear: got %h required 0", {crout, sum});
            end
        end else begin
            reset = rst;
            op1   = a;
            op2   = b;
        end
        if (!rst) begin
            exp_q.push_back(65'd0);
            pipe.delete();
            repeat (LAT - 1) pipe.push_back(65'd0);
        end else begin
            pipe.push_back(res);
            exp_q.push_back(pipe.pop_front());
        end
    endtask

    // Monitor: one expected entry per edge, sampled 1 time unit after the edge.
    initial begin
        logic [64:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({crout, sum} !== e) begin
                    n_bad++;
                    $display("FAIL result[%0d]: got %h required %h", mon_idx, {crout, sum}, e);
                end
                mon_idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        reset = 1'b0;
        op1   = 64'hdead_beef_0123_4567;
        op2   = 64'h1111_2222_3333_4444;
        repeat (LAT - 1) pipe.push_back(65'd0);
        #1;
        n_cmp++;
        if ({crout, sum} !== 65'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h required 0", {crout, sum});
        end

        drive(1'b0, 64'hdead_beef_0123_4567, 64'h1111_2222_3333_4444, 65'd0);
        drive(1'b0, 64'hffff_ffff_ffff_ffff, 64'h0000_0000_0000_0001, 65'd0);

        for (int i = 0; i < NDIR; i++) drive(1'b1, d_a[i], d_b[i], d_e[i]);

        for (int i = 0; i < 200; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            if (i == 100 || i == 101) drive(1'b0, a, b, 65'd0);
            else drive(1'b1, a, b, {1'b0, a} + {1'b0, b});
        end

        repeat (LAT + 2) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
